ps2_transmitter: RTL and testbench
==================================

PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 2500, setting the clock-inhibit time in Master_Clock_In cycles (100 us at 25 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 375000, setting the per-edge device-response timeout (15 ms at 25 MHz).
REQ-003 The block SHALL have port Master_Clock_In, input, 1 bit: the single system clock (25 MHz).
REQ-004 The block SHALL have port Reset_N_In, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port Tx_Data, input, 8 bits: the command byte to send to the keyboard.
REQ-006 The block SHALL have port Tx_Start, input, 1 bit: a one-cycle request to send Tx_Data.
REQ-007 The block SHALL have port PS2_CLK_In, input, 1 bit: the sensed PS/2 clock line (asynchronous).
REQ-008 The block SHALL have port PS2_DATA_In, input, 1 bit: the sensed PS/2 data line (asynchronous).
REQ-009 The block SHALL have port PS2_CLK_Drive_Low, output, 1 bit: 1 pulls the clock line low; 0 releases it (open-drain).
REQ-010 The block SHALL have port PS2_DATA_Drive_Low, output, 1 bit: 1 pulls the data line low; 0 releases it.
REQ-011 The block SHALL have port Tx_Busy, output, 1 bit: high from acceptance of a start until the DONE or ERROR exit.
REQ-012 The block SHALL have port Tx_Done, output, 1 bit: a one-cycle pulse when the keyboard ACKs the byte.
REQ-013 The block SHALL have port Tx_Error, output, 1 bit: a one-cycle pulse on NACK or timeout.

Function
REQ-014 PS2_CLK_In and PS2_DATA_In SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected as sync 1 then 0 on consecutive cycles.
REQ-015 The state machine SHALL use states IDLE, INHIBIT, REQ, SHIFT, STOP, ACK, WAIT_IDLE, DONE and ERROR.
REQ-016 In IDLE, both drives SHALL be 0; Tx_Start=1 SHALL latch Tx_Data, compute odd parity (bit = ~^Tx_Data), assert Tx_Busy the next cycle, and enter INHIBIT.
REQ-017 Tx_Start SHALL be ignored while Tx_Busy=1.
REQ-018 In INHIBIT, PS2_CLK_Drive_Low SHALL be 1 for exactly INHIBIT_CYCLES cycles; PS2_DATA_Drive_Low SHALL rise to 1 in the last inhibit cycle; the FSM then enters REQ.
REQ-019 In REQ, PS2_CLK_Drive_Low SHALL be 0 and PS2_DATA_Drive_Low SHALL be 1 (start bit); the first falling edge SHALL enter SHIFT with bit index 0.
REQ-020 In SHIFT, the data line SHALL present frame bit k (k=0..7 = Tx_Data[k] LSB first, k=8 = parity), with PS2_DATA_Drive_Low = ~bit.
REQ-021 Frame bit k SHALL be driven from the cycle after falling edge k+1; after bit 8 is driven, the next falling edge SHALL enter STOP.
REQ-022 In STOP, PS2_DATA_Drive_Low SHALL be 0 (stop bit = 1); the next falling edge SHALL enter ACK.
REQ-023 In ACK, the synchronized data line SHALL be sampled on the falling edge that follows the stop bit; 0 = ACK, go to WAIT_IDLE; 1 = NACK, go to ERROR.
REQ-024 In WAIT_IDLE, the FSM SHALL wait until synchronized clock and data are both 1, then enter DONE.
REQ-025 DONE SHALL pulse Tx_Done for one cycle, clear Tx_Busy, and return to IDLE.
REQ-026 ERROR SHALL pulse Tx_Error for one cycle, release both drives, clear Tx_Busy, and return to IDLE.
REQ-027 A timeout counter SHALL be cleared on entry to REQ and on every falling edge.
REQ-028 In REQ, SHIFT, STOP, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES SHALL enter ERROR.
REQ-029 Tx_Done and Tx_Error SHALL never be asserted in the same cycle.
REQ-030 Exactly one of Tx_Done or Tx_Error SHALL pulse per accepted start.
REQ-031 The block SHALL be synthesizable in 120-400 RTL lines with no latches.

Reset
REQ-032 Reset_N_In=0 SHALL asynchronously force IDLE, both drives 0, Tx_Busy/Tx_Done/Tx_Error 0, and all counters, shift register and bit index 0.
REQ-033 Reset mid-frame SHALL release both lines immediately with no Tx_Done/Tx_Error pulse; the first start after release SHALL begin a fresh frame.

Verification
REQ-034 Send 0xED with the device model clocking at 12.5 kHz and ACKing -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; Tx_Done pulses once; Tx_Busy falls.
REQ-035 Send 0xF4 -> clock driven low for exactly 2500 cycles; bits 0,0,1,0,1,1,1,1, parity 0; Tx_Done pulses once.
REQ-036 Send 0x00 with the device leaving data high at the ACK edge -> parity bit 1 sent, Tx_Error pulses once, Tx_Done stays 0.
REQ-037 Send with no device clock -> Tx_Error is asserted 375000 cycles after REQ entry, both drives 0, back in IDLE.
REQ-038 Tx_Start=1 with 0x55 in the middle of a 0xED frame -> ignored, frame bits still match 0xED.
REQ-039 Reset_N_In=0 mid-SHIFT -> drives 0 in the same cycle, no pulses; a following 0xED send completes with Tx_Done.

Source files
------------

// File: rtl/ps2_transmitter.sv
// Purpose: host-to-device PS/2 command sender (inhibit, request-to-send, 8 data + odd parity + stop, ACK check).
// Latency: Tx_Busy the cycle after Tx_Start; the frame is paced by the device clock; one cycle of Tx_Done or Tx_Error at the end.
// Backpressure: Tx_Start is ignored while Tx_Busy is high; there is no queueing.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Start,
    input  logic       PS2_CLK_In,
    input  logic       PS2_DATA_In,
    output logic       PS2_CLK_Drive_Low,
    output logic       PS2_DATA_Drive_Low,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_Error
);

    // One counter serves both the inhibit interval and the per-edge timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, REQ, SHIFT, STOP, ACK, WAIT_IDLE, DONE, ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       sh_q, sh_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             ack_q, ack_d;

    logic clk_s, data_s, fall, timed;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;

    // Two-flop synchronizers for the open-drain lines plus the previous clock sample for edge detection.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            clk_sync_q  <= 2'b00;
            data_sync_q <= 2'b00;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK_In};
            data_sync_q <= {data_sync_q[0], PS2_DATA_In};
            clk_prev_q  <= clk_s;
        end
    end

    // State, counter, frame shift register, bit index and captured ACK bit.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            bit_idx_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            bit_idx_q <= bit_idx_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state and line-drive decode; drives come from registered state so reset releases the lines at once.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q + CNT_W'(1);
        sh_d               = sh_q;
        bit_idx_d          = bit_idx_q;
        ack_d              = ack_q;
        PS2_CLK_Drive_Low  = 1'b0;
        PS2_DATA_Drive_Low = 1'b0;
        Tx_Done            = 1'b0;
        Tx_Error           = 1'b0;
        timed              = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Tx_Start) begin
                    // Frame bit 8 is odd parity over the data byte.
                    sh_d      = {~^Tx_Data, Tx_Data};
                    bit_idx_d = '0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                PS2_CLK_Drive_Low = 1'b1;
                if (cnt_q == INH_LAST) begin
                    // Start bit goes low while the clock is still held, before release.
                    PS2_DATA_Drive_Low = 1'b1;
                    cnt_d              = '0;
                    state_d            = REQ;
                end
            end
            REQ: begin
                timed              = 1'b1;
                PS2_DATA_Drive_Low = 1'b1;
                if (fall) begin
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                timed              = 1'b1;
                PS2_DATA_Drive_Low = ~sh_q[0];
                if (fall) begin
                    if (bit_idx_q == 4'd8) begin
                        state_d = STOP;
                    end else begin
                        sh_d      = {1'b0, sh_q[8:1]};
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            STOP: begin
                timed = 1'b1;
                // The edge ending the stop bit is where the device presents its ACK.
                if (fall) begin
                    ack_d   = data_s;
                    state_d = ACK;
                end
            end
            ACK: begin
                timed   = 1'b1;
                state_d = ack_q ? ERROR : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                timed = 1'b1;
                if (clk_s && data_s) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                Tx_Done = 1'b1;
                state_d = IDLE;
            end
            ERROR: begin
                Tx_Error = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Device-response watchdog, restarted by every clock falling edge.
        if (timed) begin
            if (fall) begin
                cnt_d = '0;
            end
            if (cnt_q == TO_LAST) begin
                state_d = ERROR;
            end
        end
    end

    assign Tx_Busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_transmitter.sv
module tb_ps2_transmitter;

    localparam int INH = 20;
    localparam int TO  = 600;
    localparam int H   = 10;

    logic       Master_Clock_In = 1'b0;
    logic       Reset_N_In;
    logic [7:0] Tx_Data;
    logic       Tx_Start;
    logic       PS2_CLK_Drive_Low, PS2_DATA_Drive_Low;
    logic       Tx_Busy, Tx_Done, Tx_Error;
    logic       dev_clk, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic both_seen = 1'b0;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_line  = dev_clk & ~PS2_CLK_Drive_Low;
    assign ps2_data_line = ~dev_data_low & ~PS2_DATA_Drive_Low;

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .Master_Clock_In    (Master_Clock_In),
        .Reset_N_In         (Reset_N_In),
        .Tx_Data            (Tx_Data),
        .Tx_Start           (Tx_Start),
        .PS2_CLK_In         (ps2_clk_line),
        .PS2_DATA_In        (ps2_data_line),
        .PS2_CLK_Drive_Low  (PS2_CLK_Drive_Low),
        .PS2_DATA_Drive_Low (PS2_DATA_Drive_Low),
        .Tx_Busy            (Tx_Busy),
        .Tx_Done            (Tx_Done),
        .Tx_Error           (Tx_Error)
    );

    always #5 Master_Clock_In = ~Master_Clock_In;

    always @(negedge Master_Clock_In) begin
        if (Tx_Done)  done_cnt++;
        if (Tx_Error) err_cnt++;
        if (Tx_Done && Tx_Error) both_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       nack;
        logic [8:0] frame;   // {parity, data}, bit k is frame bit k
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Master_Clock_In);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        Tx_Data  = d;
        Tx_Start = 1'b1;
        wait_cycles(1);
        Tx_Start = 1'b0;
    endtask

    // Counts cycles with the clock held low; reports data drive at first and last inhibit cycle.
    task automatic measure_inhibit(output int len, output logic first_data, output logic last_data);
        len = 0;
        first_data = PS2_DATA_Drive_Low;
        last_data  = 1'b0;
        while (PS2_CLK_Drive_Low && len < 1000) begin
            last_data = PS2_DATA_Drive_Low;
            len++;
            wait_cycles(1);
        end
    endtask

    task automatic wait_not_busy(output logic ok);
        int n = 0;
        while (Tx_Busy && n < 200) begin
            wait_cycles(1);
            n++;
        end
        ok = !Tx_Busy;
    endtask

    // Device model: 11 clocks, reads host data on rising edges, ACKs (data low) around clock 11.
    task automatic dev_frame(input logic nack, input int poke_k, input int abort_k,
                             output logic [8:0] bits, output logic stop_bit);
        bits = '0;
        stop_bit = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == abort_k) begin
                wait_cycles(6);
                return;
            end
            wait_cycles(H);
            if (k <= 9) bits[k-1] = ps2_data_line;
            else if (k == 10) stop_bit = ps2_data_line;
            dev_clk = 1'b1;
            if (k == 10) dev_data_low = ~nack;
            if (k == 11) dev_data_low = 1'b0;
            if (k == poke_k) begin
                Tx_Data  = 8'h55;
                Tx_Start = 1'b1;
                wait_cycles(1);
                Tx_Start = 1'b0;
            end
            wait_cycles(H);
        end
    endtask

    initial begin
        int         d0, e0, len, n;
        logic       fd, ld, ok, stop_bit;
        logic [8:0] bits;

        Reset_N_In = 1'b0;
        Tx_Start = 1'b0;
        Tx_Data = 8'h00;
        dev_clk = 1'b1;
        dev_data_low = 1'b0;

        vecs[0] = '{8'hED, 1'b0, 9'h1ED, 1, 0};
        vecs[1] = '{8'hF4, 1'b0, 9'h0F4, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 9'h100, 0, 1};
        vecs[3] = '{8'hA5, 1'b0, 9'h1A5, 1, 0};
        vecs[4] = '{8'hFF, 1'b0, 9'h1FF, 1, 0};

        wait_cycles(3);
        check("rst_drives", {30'd0, PS2_CLK_Drive_Low, PS2_DATA_Drive_Low}, 32'd0);
        check("rst_busy", {31'd0, Tx_Busy}, 32'd0);
        check("rst_pulses", {30'd0, Tx_Done, Tx_Error}, 32'd0);
        Reset_N_In = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_byte(vecs[i].data);
            check("busy_after_start", {31'd0, Tx_Busy}, 32'd1);
            measure_inhibit(len, fd, ld);
            check("inhibit_len", len, INH);
            check("inhibit_first_data", {31'd0, fd}, 32'd0);
            check("inhibit_last_data", {31'd0, ld}, 32'd1);
            check("req_drives", {30'd0, PS2_CLK_Drive_Low, PS2_DATA_Drive_Low}, 32'd1);
            wait_cycles(H);
            dev_frame(vecs[i].nack, 0, 0, bits, stop_bit);
            check("frame_bits", {23'd0, bits}, {23'd0, vecs[i].frame});
            check("stop_bit", {31'd0, stop_bit}, 32'd1);
            wait_not_busy(ok);
            check("busy_falls", {31'd0, ok}, 32'd1);
            check("done_count", done_cnt - d0, vecs[i].exp_done);
            check("err_count", err_cnt - e0, vecs[i].exp_err);
            check("idle_drives", {30'd0, PS2_CLK_Drive_Low, PS2_DATA_Drive_Low}, 32'd0);
            wait_cycles(5);
        end

        // Start request mid-frame must not disturb the 0xED frame or start another.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hED);
        measure_inhibit(len, fd, ld);
        wait_cycles(H);
        dev_frame(1'b0, 4, 0, bits, stop_bit);
        check("poke_frame_bits", {23'd0, bits}, 32'h1ED);
        wait_not_busy(ok);
        check("poke_busy_falls", {31'd0, ok}, 32'd1);
        check("poke_done", done_cnt - d0, 1);
        check("poke_err", err_cnt - e0, 0);
        wait_cycles(30);
        check("poke_no_restart", {30'd0, PS2_CLK_Drive_Low, Tx_Busy}, 32'd0);

        // No device clock: error exactly TO cycles after the request phase begins.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h3C);
        measure_inhibit(len, fd, ld);
        n = 0;
        while (!Tx_Error && n < 2000) begin
            wait_cycles(1);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_drives", {30'd0, PS2_CLK_Drive_Low, PS2_DATA_Drive_Low}, 32'd0);
        wait_cycles(1);
        check("timeout_idle", {31'd0, Tx_Busy}, 32'd0);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_done", done_cnt - d0, 0);

        // Reset during the data bits releases lines immediately and emits no pulse.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hED);
        measure_inhibit(len, fd, ld);
        wait_cycles(H);
        dev_frame(1'b0, 0, 5, bits, stop_bit);
        check("mid_shift_busy", {31'd0, Tx_Busy}, 32'd1);
        check("mid_shift_bit4", {31'd0, PS2_DATA_Drive_Low}, 32'd1);
        Reset_N_In = 1'b0;
        #1;
        check("reset_drives", {30'd0, PS2_CLK_Drive_Low, PS2_DATA_Drive_Low}, 32'd0);
        check("reset_busy", {31'd0, Tx_Busy}, 32'd0);
        dev_clk = 1'b1;
        wait_cycles(3);
        Reset_N_In = 1'b1;
        wait_cycles(5);
        check("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hED);
        measure_inhibit(len, fd, ld);
        check("post_reset_inhibit", len, INH);
        wait_cycles(H);
        dev_frame(1'b0, 0, 0, bits, stop_bit);
        check("post_reset_bits", {23'd0, bits}, 32'h1ED);
        wait_not_busy(ok);
        check("post_reset_done", done_cnt - d0, 1);
        check("post_reset_err", err_cnt - e0, 0);

        check("done_err_overlap", {31'd0, both_seen}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
